// File: rtl/prog_loader_pkg.sv
// Shared types for the serial program loader: FSM state encoding, the frame
// sync byte, and the 16-bit word/address types used on the memory write port.
// Latency/backpressure: n/a (types and constants only).
package prog_loader_pkg;

   // Frame layout: SYNC, LEN_HI, LEN_LO, {DATA_HI, DATA_LO} x N, CHECKSUM.
   typedef enum logic [3:0] {
      ST_IDLE    = 4'd0,
      ST_LEN_HI  = 4'd1,
      ST_LEN_LO  = 4'd2,
      ST_DATA_HI = 4'd3,
      ST_DATA_LO = 4'd4,
      ST_WRITE   = 4'd5,
      ST_CHECK   = 4'd6,
      ST_DONE    = 4'd7,
      ST_ERROR   = 4'd8
   } state_e;

   localparam logic [7:0] SYNC = 8'hA5;

   typedef logic [15:0] word_t;
   typedef logic [15:0] addr_t;

endpackage : prog_loader_pkg

// File: rtl/prog_loader.sv
// Serial program loader: parses SYNC/length/data/checksum byte frames from a
// byte stream and writes big-endian 16-bit words to program memory.
// Latency: the write strobe fires one cycle after the low data byte is taken.
// Backpressure: o_BYTEREADY drops for the write cycle and in DONE/ERROR.
//
// Ports:
//   i_CLOCK, i_RESET        clock and synchronous active-high reset
//   i_BYTE, i_BYTEVALID     incoming byte stream
//   o_BYTEREADY             byte accepted on an edge with i_BYTEVALID high
//   o_WADDR, o_WDATA        memory write address/data, held between writes
//   o_WRITE                 one-cycle memory write strobe
//   o_IOPAUSE               holds the CPU (ClockDivisor i_IOPAUSE) until DONE
//   o_DONE, o_ERROR         sticky load status until reset
module prog_loader
   import prog_loader_pkg::*;
#(
   parameter logic [15:0] BASE_ADDR = 16'h0000,
   parameter int unsigned MAX_WORDS = 1024
) (
   input  logic        i_CLOCK,
   input  logic        i_RESET,
   input  logic [7:0]  i_BYTE,
   input  logic        i_BYTEVALID,
   output logic        o_BYTEREADY,
   output logic [15:0] o_WADDR,
   output logic [15:0] o_WDATA,
   output logic        o_WRITE,
   output logic        o_IOPAUSE,
   output logic        o_DONE,
   output logic        o_ERROR
);

   // One extra bit so a 16-bit length never aliases against the limit.
   localparam logic [16:0] MAX_W = 17'(MAX_WORDS);

   state_e      state_q, state_d;
   word_t       len_q,   len_d;
   word_t       idx_q,   idx_d;
   logic [7:0]  csum_q,  csum_d;
   logic [7:0]  hi_q,    hi_d;
   addr_t       waddr_q, waddr_d;
   word_t       wdata_q, wdata_d;

   logic        byte_rdy;
   logic        take;
   logic [16:0] idx_next;

   assign byte_rdy = (state_q == ST_IDLE)    || (state_q == ST_LEN_HI)  ||
                     (state_q == ST_LEN_LO)  || (state_q == ST_DATA_HI) ||
                     (state_q == ST_DATA_LO) || (state_q == ST_CHECK);
   assign take     = byte_rdy & i_BYTEVALID;
   assign idx_next = {1'b0, idx_q} + 17'd1;

   always_ff @(posedge i_CLOCK) begin
      if (i_RESET) begin
         state_q <= ST_IDLE;
         len_q   <= '0;
         idx_q   <= '0;
         csum_q  <= '0;
         hi_q    <= '0;
         waddr_q <= '0;
         wdata_q <= '0;
      end else begin
         state_q <= state_d;
         len_q   <= len_d;
         idx_q   <= idx_d;
         csum_q  <= csum_d;
         hi_q    <= hi_d;
         waddr_q <= waddr_d;
         wdata_q <= wdata_d;
      end
   end

   always_comb begin
      state_d = state_q;
      len_d   = len_q;
      idx_d   = idx_q;
      csum_d  = csum_q;
      hi_d    = hi_q;
      waddr_d = waddr_q;
      wdata_d = wdata_q;

      case (state_q)
         ST_IDLE: begin
            // Non-sync bytes are noise: consumed and dropped.
            if (take && (i_BYTE == SYNC)) begin
               state_d = ST_LEN_HI;
            end
         end
         ST_LEN_HI: begin
            if (take) begin
               len_d[15:8] = i_BYTE;
               csum_d      = csum_q ^ i_BYTE;
               state_d     = ST_LEN_LO;
            end
         end
         ST_LEN_LO: begin
            if (take) begin
               len_d  = {len_q[15:8], i_BYTE};
               csum_d = csum_q ^ i_BYTE;
               idx_d  = '0;
               if ({1'b0, len_d} > MAX_W) begin
                  state_d = ST_ERROR;
               end else if (len_d == 16'd0) begin
                  state_d = ST_CHECK;
               end else begin
                  state_d = ST_DATA_HI;
               end
            end
         end
         ST_DATA_HI: begin
            if (take) begin
               hi_d    = i_BYTE;
               csum_d  = csum_q ^ i_BYTE;
               state_d = ST_DATA_LO;
            end
         end
         ST_DATA_LO: begin
            // Address/data registers load here so they are valid during
            // WRITE and hold their value afterwards; wrap is plain mod 2^16.
            if (take) begin
               csum_d  = csum_q ^ i_BYTE;
               waddr_d = BASE_ADDR + idx_q;
               wdata_d = {hi_q, i_BYTE};
               state_d = ST_WRITE;
            end
         end
         ST_WRITE: begin
            idx_d = idx_next[15:0];
            if (idx_next < {1'b0, len_q}) begin
               state_d = ST_DATA_HI;
            end else begin
               state_d = ST_CHECK;
            end
         end
         ST_CHECK: begin
            if (take) begin
               state_d = (i_BYTE == csum_q) ? ST_DONE : ST_ERROR;
            end
         end
         default: begin
            // DONE and ERROR are terminal until reset.
         end
      endcase
   end

   assign o_BYTEREADY = byte_rdy;
   assign o_WADDR     = waddr_q;
   assign o_WDATA     = wdata_q;
   assign o_WRITE     = (state_q == ST_WRITE);
   assign o_IOPAUSE   = (state_q != ST_DONE);
   assign o_DONE      = (state_q == ST_DONE);
   assign o_ERROR     = (state_q == ST_ERROR);

endmodule : prog_loader

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: two instances (default parameters, and
// BASE_ADDR=FFFF/MAX_WORDS=4) driven with byte frames and random valid gaps.
// Outputs are compared every cycle against a frame-parsing reference model.
module tb_prog_loader;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst [2];
   logic        vld [2];
   logic [7:0]  byt [2];
   logic        rdy [2];
   logic        wr  [2];
   logic        iop [2];
   logic        dn  [2];
   logic        er  [2];
   logic [15:0] wa  [2];
   logic [15:0] wd  [2];

   prog_loader dut0 (
      .i_CLOCK(clk), .i_RESET(rst[0]), .i_BYTE(byt[0]), .i_BYTEVALID(vld[0]),
      .o_BYTEREADY(rdy[0]), .o_WADDR(wa[0]), .o_WDATA(wd[0]), .o_WRITE(wr[0]),
      .o_IOPAUSE(iop[0]), .o_DONE(dn[0]), .o_ERROR(er[0])
   );

   prog_loader #(.BASE_ADDR(16'hFFFF), .MAX_WORDS(4)) dut1 (
      .i_CLOCK(clk), .i_RESET(rst[1]), .i_BYTE(byt[1]), .i_BYTEVALID(vld[1]),
      .o_BYTEREADY(rdy[1]), .o_WADDR(wa[1]), .o_WDATA(wd[1]), .o_WRITE(wr[1]),
      .o_IOPAUSE(iop[1]), .o_DONE(dn[1]), .o_ERROR(er[1])
   );

   localparam logic [15:0] BASE [2] = '{16'h0000, 16'hFFFF};
   localparam int          MAXW [2] = '{1024, 4};

   int n_checks = 0;
   int n_fail   = 0;
   bit chk_en   = 1'b0;

   // Reference model: every byte consumed since the last reset, per instance.
   logic [7:0] bytes_m [2][0:4095];
   int         cnt [2];
   bit         jc  [2];   // a byte was consumed at the most recent edge

   logic [31:0] wlog0 [$];
   logic [31:0] wlog1 [$];
   logic [7:0]  frame [$];

   typedef struct packed {
      logic [1:0]  status;   // 0 loading, 1 done, 2 error
      logic        wdone;    // last consumed byte completed a data word
      logic [15:0] addr;     // most recent word's address (0 if none)
      logic [15:0] data;
   } res_t;

   // Parses the consumed-byte history from scratch and reports what the
   // loader's visible status must be.
   function automatic res_t parse(int k);
      res_t r;
      int i, p, n, d, w, nlen;
      logic [7:0] x;
      r = '0;
      n = cnt[k];
      i = 0;
      while (i < n && bytes_m[k][i] != 8'hA5) i++;
      if (i >= n) return r;
      i++;
      p = n - i;
      if (p < 2) return r;
      nlen = int'({bytes_m[k][i], bytes_m[k][i+1]});
      if (nlen > MAXW[k]) begin
         r.status = 2'd2;
         return r;
      end
      d = p - 2;
      if (d > 2 * nlen) d = 2 * nlen;
      w = d / 2;
      if (w > 0) begin
         r.addr = BASE[k] + 16'(w - 1);
         r.data = {bytes_m[k][i+2*w], bytes_m[k][i+2*w+1]};
      end
      r.wdone = (p - 2 == d) && (d > 0) && (d % 2 == 0);
      if (p - 2 > 2 * nlen) begin
         x = 8'h00;
         for (int j = i; j < i + 2 + 2 * nlen; j++) x = x ^ bytes_m[k][j];
         r.status = (x == bytes_m[k][i + 2 + 2 * nlen]) ? 2'd1 : 2'd2;
      end
      return r;
   endfunction

   function automatic bit exp_ready(int k);
      res_t r;
      r = parse(k);
      return (r.status == 2'd0) && !(jc[k] && r.wdone);
   endfunction

   always @(posedge clk) begin
      for (int k = 0; k < 2; k++) begin
         if (rst[k]) begin
            cnt[k] <= 0;
            jc[k]  <= 1'b0;
         end else if (vld[k] && exp_ready(k)) begin
            bytes_m[k][cnt[k]] <= byt[k];
            cnt[k] <= cnt[k] + 1;
            jc[k]  <= 1'b1;
         end else begin
            jc[k]  <= 1'b0;
         end
      end
   end

   task automatic check(input string name, input int k,
                        input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s[inst%0d] t=%0t: got %h, expected %h", name, k, $time, act, exp);
      end
   endtask

   // Per-cycle comparison against the model, sampled on the falling edge.
   always @(negedge clk) begin
      if (chk_en) begin
         for (int k = 0; k < 2; k++) begin
            res_t r;
            bit   ew;
            r  = parse(k);
            ew = jc[k] && r.wdone;
            check("o_WRITE",     k, 32'(wr[k]),  32'(ew));
            check("o_BYTEREADY", k, 32'(rdy[k]), 32'((r.status == 2'd0) && !ew));
            check("o_WADDR",     k, 32'(wa[k]),  32'(r.addr));
            check("o_WDATA",     k, 32'(wd[k]),  32'(r.data));
            check("o_DONE",      k, 32'(dn[k]),  32'(r.status == 2'd1));
            check("o_ERROR",     k, 32'(er[k]),  32'(r.status == 2'd2));
            check("o_IOPAUSE",   k, 32'(iop[k]), 32'(r.status != 2'd1));
         end
         if (wr[0] === 1'b1) wlog0.push_back({wa[0], wd[0]});
         if (wr[1] === 1'b1) wlog1.push_back({wa[1], wd[1]});
      end
   end

   // All driver tasks start and end at 1 time unit after a rising edge.
   task automatic do_reset(input int k);
      rst[k] = 1'b1;
      vld[k] = 1'b1;             // offered byte must be discarded by reset
      byt[k] = 8'hA5;
      repeat (2) begin @(posedge clk); #1; end
      rst[k] = 1'b0;
      vld[k] = 1'b0;
      if (k == 0) wlog0.delete(); else wlog1.delete();
   endtask

   task automatic send_byte(input int k, input logic [7:0] b);
      int n0;
      int gap;
      gap = $urandom_range(0, 3);
      for (int g = 0; g < gap; g++) begin
         vld[k] = 1'b0;
         byt[k] = 8'($urandom);
         @(posedge clk); #1;
      end
      vld[k] = 1'b1;
      byt[k] = b;
      n0 = cnt[k];
      for (int t = 0; t < 20 && cnt[k] == n0; t++) begin
         @(posedge clk); #1;
      end
      vld[k] = 1'b0;
      byt[k] = 8'($urandom);
      if (cnt[k] == n0) begin
         n_checks++;
         n_fail++;
         $display("FAIL byte_accept[inst%0d]: byte %h not taken within 20 cycles", k, b);
      end
   endtask

   task automatic send_frame(input int k);
      foreach (frame[i]) send_byte(k, frame[i]);
   endtask

   task automatic build_frame(input int n, input bit good, input int noise);
      logic [7:0] b, cs;
      frame.delete();
      for (int i = 0; i < noise; i++) begin
         b = 8'($urandom);
         if (b == 8'hA5) b = 8'h5A;
         frame.push_back(b);
      end
      frame.push_back(8'hA5);
      cs = 8'(n >> 8) ^ 8'(n);
      frame.push_back(8'(n >> 8));
      frame.push_back(8'(n));
      for (int i = 0; i < 2 * n; i++) begin
         b = 8'($urandom);
         cs = cs ^ b;
         frame.push_back(b);
      end
      if (!good) cs = cs ^ 8'($urandom_range(1, 255));
      frame.push_back(cs);
   endtask

   task automatic offer_idle_bytes(input int k);
      vld[k] = 1'b1;
      repeat (4) begin byt[k] = 8'($urandom); @(posedge clk); #1; end
      vld[k] = 1'b0;
   endtask

   initial begin
      int nw;
      bit good;
      for (int k = 0; k < 2; k++) begin
         rst[k] = 1'b1; vld[k] = 1'b0; byt[k] = 8'h00;
      end
      @(posedge clk); #1;
      chk_en = 1'b1;
      @(posedge clk); #1;
      rst[0] = 1'b0; rst[1] = 1'b0;

      // Reset values.
      check("rst_ready",   0, 32'(rdy[0]), 32'd1);
      check("rst_iopause", 0, 32'(iop[0]), 32'd1);
      check("rst_done",    0, 32'(dn[0]),  32'd0);
      check("rst_waddr",   0, 32'(wa[0]),  32'd0);

      // Two-word frame with a correct checksum.
      frame = '{8'hA5, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h42};
      send_frame(0);
      check("A_nwrites", 0, 32'(wlog0.size()), 32'd2);
      if (wlog0.size() == 2) begin
         check("A_write0", 0, wlog0[0], 32'h0000_1234);
         check("A_write1", 0, wlog0[1], 32'h0001_ABCD);
      end
      check("A_done",    0, 32'(dn[0]),  32'd1);
      check("A_iopause", 0, 32'(iop[0]), 32'd0);
      offer_idle_bytes(0);
      check("A_done_sticky", 0, 32'(dn[0]), 32'd1);

      // Same frame, bad checksum.
      do_reset(0);
      frame = '{8'hA5, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h45};
      send_frame(0);
      check("B_nwrites", 0, 32'(wlog0.size()), 32'd2);
      check("B_error",   0, 32'(er[0]),  32'd1);
      check("B_iopause", 0, 32'(iop[0]), 32'd1);
      check("B_ready",   0, 32'(rdy[0]), 32'd0);
      offer_idle_bytes(0);

      // Noise then an empty program.
      do_reset(0);
      frame = '{8'h00, 8'hFF, 8'hA5, 8'h00, 8'h00, 8'h00};
      send_frame(0);
      check("C_nwrites", 0, 32'(wlog0.size()), 32'd0);
      check("C_done",    0, 32'(dn[0]), 32'd1);

      // Random frames on the default instance.
      for (int it = 0; it < 8; it++) begin
         do_reset(0);
         nw   = $urandom_range(1, 9);
         good = ($urandom_range(0, 3) != 0);
         build_frame(nw, good, $urandom_range(0, 3));
         send_frame(0);
         check("R_nwrites", 0, 32'(wlog0.size()), 32'(nw));
         check("R_done",    0, 32'(dn[0]), 32'(good));
         check("R_error",   0, 32'(er[0]), 32'(!good));
      end

      // Length above MAX_WORDS: error right after the length.
      do_reset(1);
      frame = '{8'hA5, 8'h00, 8'h05};
      send_frame(1);
      check("M_error",   1, 32'(er[1]), 32'd1);
      check("M_nwrites", 1, 32'(wlog1.size()), 32'd0);
      offer_idle_bytes(1);

      // Address wrap at FFFF, and length exactly MAX_WORDS.
      do_reset(1);
      build_frame(2, 1'b1, 0);
      send_frame(1);
      check("W_nwrites", 1, 32'(wlog1.size()), 32'd2);
      if (wlog1.size() == 2) begin
         check("W_addr0", 1, 32'(wlog1[0][31:16]), 32'h0000_FFFF);
         check("W_addr1", 1, 32'(wlog1[1][31:16]), 32'h0000_0000);
      end
      check("W_done", 1, 32'(dn[1]), 32'd1);
      do_reset(1);
      build_frame(4, 1'b1, 1);
      send_frame(1);
      check("X_nwrites", 1, 32'(wlog1.size()), 32'd4);
      check("X_done",    1, 32'(dn[1]), 32'd1);

      // Reset asserted while the write strobe is high, then a full reload.
      do_reset(0);
      frame = '{8'hA5, 8'h00, 8'h03, 8'h11, 8'h22};
      send_frame(0);
      check("Z_write_now", 0, 32'(wr[0]), 32'd1);
      check("Z_wdata",     0, 32'(wd[0]), 32'h0000_1122);
      rst[0] = 1'b1;
      vld[0] = 1'b1;
      byt[0] = 8'h33;
      @(posedge clk); #1;
      rst[0] = 1'b0;
      vld[0] = 1'b0;
      check("Z_write_after", 0, 32'(wr[0]),  32'd0);
      check("Z_ready_after", 0, 32'(rdy[0]), 32'd1);
      check("Z_waddr_after", 0, 32'(wa[0]),  32'd0);
      wlog0.delete();
      build_frame(3, 1'b1, 0);
      send_frame(0);
      check("Z_reload_writes", 0, 32'(wlog0.size()), 32'd3);
      check("Z_reload_done",   0, 32'(dn[0]), 32'd1);

      repeat (3) @(posedge clk);
      #1;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule : tb_prog_loader
